// File: rtl/fifo_command_reader_if.sv
// Bundle between the byte-FIFO read port, the command reader and the renderer decoder.
// master = command reader, slave = FIFO/decoder side.
interface fifo_command_reader_if #(
    parameter int MAX_PAYLOAD = 8,
    parameter int WIDTH       = 8
);
    logic                     i_read_available;
    logic [WIDTH-1:0]         i_read_data;
    logic                     o_read_data_consumed;
    logic                     o_cmd_valid;
    logic [3:0]               o_cmd_opcode;
    logic [3:0]               o_cmd_length;
    logic [8*MAX_PAYLOAD-1:0] o_cmd_payload;
    logic                     i_cmd_ready;
    logic                     o_error;

    modport master (
        input  i_read_available, i_read_data, i_cmd_ready,
        output o_read_data_consumed, o_cmd_valid, o_cmd_opcode, o_cmd_length,
               o_cmd_payload, o_error
    );

    modport slave (
        output i_read_available, i_read_data, i_cmd_ready,
        input  o_read_data_consumed, o_cmd_valid, o_cmd_opcode, o_cmd_length,
               o_cmd_payload, o_error
    );
endinterface

// File: rtl/fifo_command_reader.sv
// Pops header+payload frames from the byte FIFO and presents them as renderer commands.
// Latency: command valid the cycle after its last byte is taken; at most 1 byte per 2 cycles.
// Backpressure: holds the command stable and stops popping until i_cmd_ready accepts it.
module fifo_command_reader #(
    parameter int MAX_PAYLOAD = 8,
    parameter int WIDTH       = 8
) (
    input  logic                   i_master_clk,
    input  logic                   i_reset_n,
    fifo_command_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD, PRESENT} state_t;

    state_t                   state_q, state_d;
    logic                     pop_q, pop_d;
    logic [3:0]               count_q, count_d;
    logic [3:0]               opcode_q, opcode_d;
    logic [3:0]               length_q, length_d;
    logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;

    logic [7:0] rd_byte;
    logic       last_byte;

    assign rd_byte   = bus.i_read_data[7:0];
    assign last_byte = (count_q == length_q - 4'd1);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        opcode_d  = opcode_q;
        length_d  = length_q;
        payload_d = payload_q;

        // pop_q high means this cycle's i_read_data is the byte being taken
        unique case (state_q)
            IDLE: begin
                if (pop_q) begin
                    opcode_d  = rd_byte[7:4];
                    length_d  = rd_byte[3:0];
                    payload_d = '0;
                    count_d   = 4'd0;
                    if (rd_byte[3:0] == 4'd0)
                        state_d = PRESENT;
                    else if (rd_byte[3:0] > 4'(MAX_PAYLOAD))
                        state_d = DISCARD;
                    else
                        state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pop_q) begin
                    for (int k = 0; k < MAX_PAYLOAD; k++) begin
                        if (count_q == 4'(k))
                            payload_d[8*k +: 8] = rd_byte;
                    end
                    if (last_byte) begin
                        count_d = 4'd0;
                        state_d = PRESENT;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            DISCARD: begin
                if (pop_q) begin
                    if (last_byte) begin
                        count_d = 4'd0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            PRESENT: begin
                if (bus.i_cmd_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance cycle may already request the next header pop; it lands in IDLE.
        pop_d = bus.i_read_available && !pop_q &&
                ((state_q != PRESENT) || bus.i_cmd_ready);
    end

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            pop_q     <= 1'b0;
            count_q   <= 4'd0;
            opcode_q  <= 4'd0;
            length_q  <= 4'd0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            pop_q     <= pop_d;
            count_q   <= count_d;
            opcode_q  <= opcode_d;
            length_q  <= length_d;
            payload_q <= payload_d;
        end
    end

    assign bus.o_read_data_consumed = pop_q;
    assign bus.o_cmd_valid          = (state_q == PRESENT);
    assign bus.o_cmd_opcode         = opcode_q;
    assign bus.o_cmd_length         = length_q;
    assign bus.o_cmd_payload        = payload_q;
    assign bus.o_error              = (state_q == DISCARD) && pop_q && last_byte;
endmodule

// File: tb/tb_fifo_command_reader.sv
// Directed bench for fifo_command_reader: a queue-backed FIFO model feeds frames,
// commands/pops/errors are logged per cycle and checked against hand-computed values.
module tb_fifo_command_reader;
    logic clk;
    logic rst_n;

    fifo_command_reader_if #(.MAX_PAYLOAD(8), .WIDTH(8)) bus ();

    fifo_command_reader #(.MAX_PAYLOAD(8), .WIDTH(8)) dut (
        .i_master_clk (clk),
        .i_reset_n    (rst_n),
        .bus          (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;

    int pops, consec, errs, err_pop_idx, ncmd;
    int last_pop_cyc, first_valid_cyc;
    logic prev_pop, prev_valid;
    logic s_pop, s_valid, s_err;
    logic [3:0]  s_op, s_len, c_op, c_len;
    logic [63:0] s_pay, c_pay;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.i_read_available = (q.size() != 0);
        bus.i_read_data      = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        refresh();
    endtask

    task automatic clr();
        pops = 0; consec = 0; errs = 0; err_pop_idx = -1; ncmd = 0;
        last_pop_cyc = -100; first_valid_cyc = -1;
    endtask

    // One clock: sample at negedge, advance FIFO model just after posedge.
    task automatic tick();
        logic [7:0] tmp;
        @(negedge clk);
        s_pop = bus.o_read_data_consumed;
        s_valid = bus.o_cmd_valid;
        s_err = bus.o_error;
        s_op = bus.o_cmd_opcode;
        s_len = bus.o_cmd_length;
        s_pay = bus.o_cmd_payload;
        if (s_pop) begin
            pops++;
            if (prev_pop) consec++;
        end
        prev_pop = s_pop;
        if (s_err) begin
            errs++;
            err_pop_idx = pops;
        end
        if (s_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (s_pop) last_pop_cyc = cyc;
        prev_valid = s_valid;
        if (s_valid && bus.i_cmd_ready) begin
            ncmd++;
            c_op = s_op; c_len = s_len; c_pay = s_pay;
        end
        @(posedge clk);
        #1;
        if (s_pop && q.size() != 0) tmp = q.pop_front();
        refresh();
        cyc++;
    endtask

    task automatic wait_cmd(input string tag, input int target, input int budget);
        int k = 0;
        while (ncmd < target && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 64'(ncmd >= target), 64'd1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k, bad, pops_before;
        rst_n = 1'b0;
        bus.i_cmd_ready = 1'b0;
        prev_pop = 1'b0; prev_valid = 1'b0;
        refresh();
        clr();

        // Reset state
        ticks(3);
        chk("rst_consumed", 64'(bus.o_read_data_consumed), 64'd0);
        chk("rst_valid",    64'(bus.o_cmd_valid), 64'd0);
        chk("rst_error",    64'(bus.o_error), 64'd0);
        chk("rst_opcode",   64'(bus.o_cmd_opcode), 64'd0);
        chk("rst_length",   64'(bus.o_cmd_length), 64'd0);
        chk("rst_payload",  bus.o_cmd_payload, 64'd0);
        rst_n = 1'b1;
        ticks(2);

        // Basic 2-byte frame
        clr();
        bus.i_cmd_ready = 1'b1;
        push(8'h32); push(8'hAA); push(8'hBB);
        wait_cmd("f32", 1, 40);
        ticks(5);
        chk("f32_opcode", 64'(c_op), 64'd3);
        chk("f32_length", 64'(c_len), 64'd2);
        chk("f32_payload", c_pay, 64'h0000_0000_0000_BBAA);
        chk("f32_pops", 64'(pops), 64'd3);
        chk("f32_consec", 64'(consec), 64'd0);
        chk("f32_ncmd", 64'(ncmd), 64'd1);

        // Zero-length frame
        clr();
        push(8'h70);
        wait_cmd("f70", 1, 20);
        ticks(3);
        chk("f70_opcode", 64'(c_op), 64'd7);
        chk("f70_length", 64'(c_len), 64'd0);
        chk("f70_payload", c_pay, 64'd0);
        chk("f70_pops", 64'(pops), 64'd1);
        chk("f70_valid_lat", 64'(first_valid_cyc - last_pop_cyc), 64'd1);

        // Oversize frame dropped, then a 1-byte frame
        clr();
        push(8'h1A);
        for (int i = 0; i < 10; i++) push(8'(8'hC0 + i));
        push(8'h21); push(8'h55);
        wait_cmd("f1a", 1, 80);
        ticks(3);
        chk("f1a_errs", 64'(errs), 64'd1);
        chk("f1a_err_at_pop", 64'(err_pop_idx), 64'd11);
        chk("f1a_ncmd", 64'(ncmd), 64'd1);
        chk("f1a_opcode", 64'(c_op), 64'd2);
        chk("f1a_length", 64'(c_len), 64'd1);
        chk("f1a_payload", c_pay, 64'h55);
        chk("f1a_pops", 64'(pops), 64'd13);

        // Stall with next frame waiting in the FIFO
        clr();
        bus.i_cmd_ready = 1'b0;
        push(8'h21); push(8'h66); push(8'h10);
        k = 0;
        while (!s_valid && k < 40) begin
            tick();
            k++;
        end
        chk("stall_valid_seen", 64'(s_valid), 64'd1);
        pops_before = pops;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_valid !== 1'b1 || s_op !== 4'd2 || s_len !== 4'd1 || s_pay !== 64'h66) bad++;
        end
        chk("stall_stable", 64'(bad), 64'd0);
        chk("stall_pops", 64'(pops - pops_before), 64'd0);
        bus.i_cmd_ready = 1'b1;
        tick();
        chk("stall_accept_no_pop", 64'(s_pop), 64'd0);
        tick();
        chk("stall_pop_resume", 64'(s_pop), 64'd1);
        wait_cmd("stall_next", 2, 20);
        chk("stall_next_opcode", 64'(c_op), 64'd1);
        chk("stall_next_length", 64'(c_len), 64'd0);

        // FIFO empty mid-frame
        ticks(3);
        clr();
        push(8'h43); push(8'h11);
        ticks(50);
        chk("empty_errs", 64'(errs), 64'd0);
        chk("empty_ncmd", 64'(ncmd), 64'd0);
        chk("empty_valid", 64'(s_valid), 64'd0);
        push(8'h22); push(8'h33);
        wait_cmd("empty", 1, 30);
        chk("empty_opcode", 64'(c_op), 64'd4);
        chk("empty_length", 64'(c_len), 64'd3);
        chk("empty_payload", c_pay, 64'h33_2211);
        chk("empty_consec", 64'(consec), 64'd0);

        // Reset in the middle of a payload
        ticks(3);
        clr();
        push(8'h44); push(8'hA1);
        ticks(10);
        chk("mid_opcode_before", 64'(bus.o_cmd_opcode), 64'd4);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_opcode", 64'(bus.o_cmd_opcode), 64'd0);
        chk("mid_rst_length", 64'(bus.o_cmd_length), 64'd0);
        chk("mid_rst_valid", 64'(bus.o_cmd_valid), 64'd0);
        chk("mid_rst_consumed", 64'(bus.o_read_data_consumed), 64'd0);
        chk("mid_rst_error", 64'(bus.o_error), 64'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        clr();
        push(8'h52); push(8'h01); push(8'h02);
        wait_cmd("post_rst", 1, 30);
        chk("post_rst_opcode", 64'(c_op), 64'd5);
        chk("post_rst_length", 64'(c_len), 64'd2);
        chk("post_rst_payload", c_pay, 64'h0201);

        // Reset while a command is presented clears valid without a clock edge
        ticks(3);
        bus.i_cmd_ready = 1'b0;
        push(8'h60);
        k = 0;
        while (!s_valid && k < 20) begin
            tick();
            k++;
        end
        chk("pres_valid_seen", 64'(s_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("pres_rst_valid", 64'(bus.o_cmd_valid), 64'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
